mux_operand_loader: RTL and testbench

Front-end stage that feeds the 8-bit 2:1 operand mux on the lab board. It captures operand x and operand y from the eight slide switches under control of a debounced pushbutton, and toggles the mux select from a second debounced pushbutton. Its x, y and s outputs connect directly to the mux's x, y and s inputs. A status output drives the spare LEDs.

---
 rtl/mux_operand_loader.sv | 162 ++++++++++++++++
 tb/tb_mux_operand_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_operand_loader.sv
// Switch/pushbutton front-end for the lab 8-bit 2:1 operand mux: loads x/y from sw and toggles s.
// Define MUX_OPERAND_LOADER_DEBOUNCE_EN to build the debounce counters (undefined: fast-sim bypass).
module mux_operand_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic       key_load_n,
    input  logic       key_sel_n,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic       s,
    output logic       target,
    output logic       load_done,
    output logic [5:0] status
);

    typedef enum logic {LOAD_X = 1'b0, LOAD_Y = 1'b1} state_t;

    // Bit 0 is the load button, bit 1 the select button.
    logic [1:0]  key_raw;
    logic [1:0]  key_meta_q, key_sync_q;
    logic [1:0]  key_stable_q, key_stable_d;
    logic [1:0]  key_prev_q, press_q;
    logic [7:0]  sw_meta_q, sw_sync_q;
    state_t      state_q, state_d;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic        s_q, s_d;
    logic        load_done_q, load_done_d;
    logic        stretch_q, stretch_d;
    logic [21:0] stretch_cnt_q, stretch_cnt_d;

    assign key_raw = {key_sel_n, key_load_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q <= '1;
            key_sync_q <= '1;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            key_meta_q <= key_raw;
            key_sync_q <= key_meta_q;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
        end
    end

`ifdef MUX_OPERAND_LOADER_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    // The count restarts whenever the synced level agrees with the stable one, so any bounce restarts it.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            key_stable_d[i] = key_stable_q[i];
            cnt_d[i]        = '0;
            if (key_sync_q[i] != key_stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    key_stable_d[i] = ~key_stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{DEBOUNCE_CYCLES, CNT_W};

    always_comb key_stable_d = key_sync_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_stable_q <= '1;
            key_prev_q   <= '1;
            press_q      <= '0;
        end else begin
            key_stable_q <= key_stable_d;
            key_prev_q   <= key_stable_q;
            press_q      <= key_prev_q & ~key_stable_q;
        end
    end

    // Load and select presses act independently, so both land on the same edge when coincident.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        s_d         = s_q;
        load_done_d = 1'b0;
        if (press_q[0]) begin
            load_done_d = 1'b1;
            case (state_q)
                LOAD_X:  begin x_d = sw_sync_q; state_d = LOAD_Y; end
                LOAD_Y:  begin y_d = sw_sync_q; state_d = LOAD_X; end
                default: state_d = LOAD_X;
            endcase
        end
        if (press_q[1]) begin
            s_d = ~s_q;
        end
    end

    always_comb begin
        stretch_d     = stretch_q;
        stretch_cnt_d = stretch_cnt_q;
        if (load_done_q) begin
            stretch_d     = 1'b1;
            stretch_cnt_d = '0;
        end else if (stretch_q) begin
            if (&stretch_cnt_q) begin
                stretch_d     = 1'b0;
                stretch_cnt_d = '0;
            end else begin
                stretch_cnt_d = stretch_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LOAD_X;
            x_q           <= '0;
            y_q           <= '0;
            s_q           <= 1'b0;
            load_done_q   <= 1'b0;
            stretch_q     <= 1'b0;
            stretch_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            s_q           <= s_d;
            load_done_q   <= load_done_d;
            stretch_q     <= stretch_d;
            stretch_cnt_q <= stretch_cnt_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign s         = s_q;
    assign target    = (state_q == LOAD_Y);
    assign load_done = load_done_q;
    assign status    = {target, s_q, 1'b0, stretch_q, 2'b00};

endmodule

// File: tb/tb_mux_operand_loader.sv
// Bench for mux_operand_loader: directed vector table, hand-written corner sequences and a
// randomized button/switch run scored cycle by cycle against a behavioural model.
module tb_mux_operand_loader;

    localparam int D  = 4;
    localparam int HN = D + 3;
`ifdef MUX_OPERAND_LOADER_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
    localparam int LAT = D + 4;
`else
    localparam bit DEB = 1'b0;
    localparam int LAT = 5;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw;
    logic       key_load_n, key_sel_n;
    logic [7:0] x, y;
    logic       s, target, load_done;
    logic [5:0] status;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_operand_loader #(.DEBOUNCE_CYCLES(D), .CNT_W(19)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .key_load_n (key_load_n),
        .key_sel_n  (key_sel_n),
        .x          (x),
        .y          (y),
        .s          (s),
        .target     (target),
        .load_done  (load_done),
        .status     (status)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Histories are indexed by age: [0] = value at the current edge, [k] = k edges ago.
    logic       kl_h [HN];
    logic       ks_h [HN];
    logic [7:0] sw_h [3];
    logic       sl_h [4];
    logic       ss_h [4];
    logic [7:0] mx, my;
    logic       ms, mt, mld, mst;
    longint     ecnt, last_ld;
    bit         has_ld;

    // A button's clean level follows the raw input only after D consecutive samples of the new
    // level (raw samples reach the debouncer two edges late); without debouncing it simply follows.
    function automatic logic next_stable(input logic h [HN], input logic cur);
        if (!DEB) return h[2];
        for (int j = 0; j < D; j++) if (h[2+j] == cur) return cur;
        return ~cur;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < HN; i++) begin kl_h[i] = 1'b1; ks_h[i] = 1'b1; end
        for (int i = 0; i < 3; i++) sw_h[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin sl_h[i] = 1'b1; ss_h[i] = 1'b1; end
        mx = 8'h00; my = 8'h00; ms = 1'b0; mt = 1'b0; mld = 1'b0; mst = 1'b0;
        ecnt = 0; last_ld = 0; has_ld = 1'b0;
    endtask

    task automatic model_step(input logic kl, input logic ks, input logic [7:0] swv);
        logic nl, ns, pl, ps;
        ecnt++;
        if (mld) begin has_ld = 1'b1; last_ld = ecnt; end
        for (int i = HN - 1; i > 0; i--) begin kl_h[i] = kl_h[i-1]; ks_h[i] = ks_h[i-1]; end
        kl_h[0] = kl;
        ks_h[0] = ks;
        sw_h[2] = sw_h[1]; sw_h[1] = sw_h[0]; sw_h[0] = swv;
        nl = next_stable(kl_h, sl_h[0]);
        ns = next_stable(ks_h, ss_h[0]);
        for (int i = 3; i > 0; i--) begin sl_h[i] = sl_h[i-1]; ss_h[i] = ss_h[i-1]; end
        sl_h[0] = nl;
        ss_h[0] = ns;
        // A clean 1->0 two edges ago is the press that takes effect now.
        pl = (sl_h[2] == 1'b0) && (sl_h[3] == 1'b1);
        ps = (ss_h[2] == 1'b0) && (ss_h[3] == 1'b1);
        mld = pl;
        if (pl) begin
            if (!mt) mx = sw_h[2]; else my = sw_h[2];
            mt = ~mt;
        end
        if (ps) ms = ~ms;
        mst = has_ld && ((ecnt - last_ld) < 64'd4194304);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else        model_step(key_load_n, key_sel_n, sw);
            #1;
            check("cycle", 32'({x, y, s, target, load_done, status}),
                  32'({mx, my, ms, mt, mld, mt, ms, 1'b0, mst, 2'b00}));
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [7:0] swv;
        bit         ld;
        bit         sl;
        logic [7:0] ex;
        logic [7:0] ey;
        logic       es;
        logic       et;
    } vec_t;

    vec_t tbl [6];
    int   pulses;
    int   cl, cs;

    initial begin
        tbl[0] = '{8'hC3, 1'b1, 1'b0, 8'h3C, 8'hC3, 1'b0, 1'b0};
        tbl[1] = '{8'h81, 1'b1, 1'b1, 8'h81, 8'hC3, 1'b1, 1'b1};
        tbl[2] = '{8'h5A, 1'b0, 1'b1, 8'h81, 8'hC3, 1'b0, 1'b1};
        tbl[3] = '{8'h99, 1'b1, 1'b0, 8'h81, 8'h99, 1'b0, 1'b0};
        tbl[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 8'h99, 1'b1, 1'b1};
        tbl[5] = '{8'hFF, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0};

        rst_n = 1'b0; sw = 8'hA5; key_load_n = 1'b1; key_sel_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x", 32'(x), 32'h00);
        check("rst_y", 32'(y), 32'h00);
        check("rst_s", 32'(s), 32'h0);
        check("rst_target", 32'(target), 32'h0);
        check("rst_load_done", 32'(load_done), 32'h0);
        check("rst_status", 32'(status), 32'h00);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_load_done", 32'(load_done), 32'h0);
        check("idle_x", 32'(x), 32'h00);

        // First load: exact latency, single pulse while held.
        @(negedge clk); sw = 8'h3C; key_load_n = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        check("lat_x_before", 32'(x), 32'h00);
        check("lat_ld_before", 32'(load_done), 32'h0);
        @(posedge clk); #1;
        check("lat_x", 32'(x), 32'h3C);
        check("lat_y", 32'(y), 32'h00);
        check("lat_target", 32'(target), 32'h1);
        check("lat_load_done", 32'(load_done), 32'h1);
        pulses = 0;
        repeat (12) begin @(posedge clk); #1; if (load_done) pulses++; end
        check("held_pulses", 32'(pulses), 32'h0);
        check("stretch_status", 32'(status), 32'h24);
        @(negedge clk) key_load_n = 1'b1;
        repeat (LAT + 4) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sw = tbl[i].swv;
            key_load_n = ~tbl[i].ld;
            key_sel_n  = ~tbl[i].sl;
            repeat (LAT + 6) @(posedge clk);
            @(negedge clk); key_load_n = 1'b1; key_sel_n = 1'b1;
            repeat (LAT + 4) @(posedge clk);
            #1;
            check($sformatf("vec%0d_x", i), 32'(x), 32'(tbl[i].ex));
            check($sformatf("vec%0d_y", i), 32'(y), 32'(tbl[i].ey));
            check($sformatf("vec%0d_s", i), 32'(s), 32'(tbl[i].es));
            check($sformatf("vec%0d_target", i), 32'(target), 32'(tbl[i].et));
        end

        // Bounce: low 3, high 1, low 3, high.
        @(negedge clk); sw = 8'h11; key_load_n = 1'b0;
        repeat (3) @(negedge clk);
        key_load_n = 1'b1;
        @(negedge clk) key_load_n = 1'b0;
        repeat (3) @(negedge clk);
        key_load_n = 1'b1;
        repeat (LAT + 6) @(posedge clk);
        #1;
        if (DEB) begin
            check("bounce_x", 32'(x), 32'h00);
            check("bounce_y", 32'(y), 32'hFF);
        end else begin
            check("bounce_x", 32'(x), 32'h11);
            check("bounce_y", 32'(y), 32'h11);
        end
        check("bounce_target", 32'(target), 32'h0);
        check("bounce_s", 32'(s), 32'h1);

        // Reset in the middle of a debounce count, key still held at release.
        @(negedge clk); sw = 8'h6E; key_load_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("midrst_outputs", 32'({x, y, s, target, load_done, status}), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1;
        check("midrst_x_before", 32'(x), 32'h00);
        check("midrst_ld_before", 32'(load_done), 32'h0);
        @(posedge clk); #1;
        check("midrst_x", 32'(x), 32'h6E);
        check("midrst_target", 32'(target), 32'h1);
        check("midrst_load_done", 32'(load_done), 32'h1);
        @(negedge clk) key_load_n = 1'b1;
        repeat (LAT + 4) @(posedge clk);

        // Randomized buttons (clean presses and bounces) and switches, scored by the model.
        cl = 0; cs = 0;
        repeat (1500) begin
            @(negedge clk);
            if ($urandom_range(7, 0) == 0) sw = 8'($urandom);
            if (cl == 0) begin key_load_n = ~key_load_n; cl = $urandom_range(2 * D + 2, 1); end
            else cl--;
            if (cs == 0) begin key_sel_n = ~key_sel_n; cs = $urandom_range(2 * D + 2, 1); end
            else cs--;
        end
        @(negedge clk); key_load_n = 1'b1; key_sel_n = 1'b1;
        repeat (LAT + 6) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
